// File: rtl/pcm_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pcm_sample_fifo
// Description : Elastic FWFT buffer between the PCM decimator and the
//               equalizer stream; drops and counts samples arriving when full.
// Revision    : 1.0 - initial release
// ============================================================================
module pcm_sample_fifo #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int AFULL_LVL = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_W-1:0]          pcm_data,
   input  logic                       pcm_data_valid,
   output logic [DATA_W-1:0]          m_tdata,
   output logic                       m_tvalid,
   input  logic                       m_tready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       almost_full,
   output logic                       overflow,
   output logic [7:0]                 ovf_count,
   input  logic                       clr_ovf
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_LVL_W = c_PTR_W + 1;
   localparam logic [c_LVL_W-1:0] c_FULL  = c_LVL_W'(DEPTH);
   localparam logic [c_LVL_W-1:0] c_AFULL = c_LVL_W'(AFULL_LVL);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
   localparam logic [c_LVL_W-1:0] c_LVL_ONE = c_LVL_W'(1);

   logic [DATA_W-1:0]  r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_LVL_W-1:0] r_level;
   logic               r_afull;
   logic               r_ovf;
   logic [7:0]         r_ovf_cnt;

   logic               w_full;
   logic               w_pop;
   logic               w_push;
   logic               w_drop;
   logic [c_LVL_W-1:0] w_level_nxt;

   assign w_full = (r_level == c_FULL);
   assign w_pop  = m_tvalid & m_tready;
   assign w_push = pcm_data_valid & (~w_full | w_pop);
   assign w_drop = pcm_data_valid & w_full & ~w_pop;

   always_comb begin
      w_level_nxt = r_level;
      if (w_push && !w_pop)
         w_level_nxt = r_level + c_LVL_ONE;
      else if (w_pop && !w_push)
         w_level_nxt = r_level - c_LVL_ONE;
   end

   // Storage is deliberately left out of reset; only pointers define validity.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= pcm_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_afull  <= 1'b0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         r_level <= w_level_nxt;
         r_afull <= (w_level_nxt >= c_AFULL);
      end
   end

   // A drop in the same cycle as a clear restarts the count at one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf     <= 1'b0;
         r_ovf_cnt <= 8'h00;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
         if (clr_ovf)
            r_ovf_cnt <= 8'h01;
         else if (r_ovf_cnt != 8'hFF)
            r_ovf_cnt <= r_ovf_cnt + 8'h01;
      end else if (clr_ovf) begin
         r_ovf     <= 1'b0;
         r_ovf_cnt <= 8'h00;
      end
   end

   assign m_tdata     = r_mem[r_rd_ptr];
   assign m_tvalid    = (r_level != '0);
   assign level       = r_level;
   assign almost_full = r_afull;
   assign overflow    = r_ovf;
   assign ovf_count   = r_ovf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pcm_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcm_sample_fifo
// Description : Directed self-checking bench for pcm_sample_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcm_sample_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] pcm_data;
   logic       pcm_data_valid;
   logic [7:0] m_tdata;
   logic       m_tvalid;
   logic       m_tready;
   logic [4:0] level;
   logic       almost_full;
   logic       overflow;
   logic [7:0] ovf_count;
   logic       clr_ovf;

   int n_cmp = 0;
   int n_err = 0;

   pcm_sample_fifo #(.DATA_W(8), .DEPTH(16), .AFULL_LVL(12)) dut (
      .clk            (clk),
      .rst            (rst),
      .pcm_data       (pcm_data),
      .pcm_data_valid (pcm_data_valid),
      .m_tdata        (m_tdata),
      .m_tvalid       (m_tvalid),
      .m_tready       (m_tready),
      .level          (level),
      .almost_full    (almost_full),
      .overflow       (overflow),
      .ovf_count      (ovf_count),
      .clr_ovf        (clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      pcm_data       = d;
      pcm_data_valid = 1'b1;
      tick();
      pcm_data_valid = 1'b0;
   endtask

   task automatic fill(input logic [7:0] base);
      for (int i = 0; i < 16; i++) push(base + 8'(i));
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] next_val;
      int         sent;
      logic       mpop;
      logic       mpush;

      rst = 1'b1; pcm_data = 8'h00; pcm_data_valid = 1'b0;
      m_tready = 1'b0; clr_ovf = 1'b0;
      tick(); tick();
      check("rst_tvalid", m_tvalid, 0);
      check("rst_level", level, 0);
      check("rst_afull", almost_full, 0);
      check("rst_ovf", overflow, 0);
      check("rst_ovfcnt", ovf_count, 0);
      rst = 1'b0;
      tick();

      // Single sample
      push(8'h5A);
      check("single_tvalid", m_tvalid, 1);
      check("single_tdata", m_tdata, 8'h5A);
      check("single_level", level, 1);
      m_tready = 1'b1; tick(); m_tready = 1'b0;
      check("single_pop_tvalid", m_tvalid, 0);
      check("single_pop_level", level, 0);

      // Fill, almost_full threshold
      for (int i = 1; i <= 16; i++) begin
         push(8'(i));
         check($sformatf("fill_level_%0d", i), level, i);
         check($sformatf("fill_afull_%0d", i), almost_full, (i >= 12) ? 1 : 0);
      end
      check("fill_ovf", overflow, 0);

      // Overflow: 3 drops, then saturation
      for (int i = 0; i < 3; i++) push(8'hE0 + 8'(i));
      check("ovf_flag", overflow, 1);
      check("ovf_cnt3", ovf_count, 3);
      check("ovf_level", level, 16);
      for (int i = 0; i < 260; i++) push(8'hF0);
      check("ovf_sat", ovf_count, 255);

      // Drain returns original data in order
      for (int i = 1; i <= 16; i++) begin
         check($sformatf("drain_data_%0d", i), m_tdata, i);
         m_tready = 1'b1; tick();
         check($sformatf("drain_level_%0d", i), level, 16 - i);
         check($sformatf("drain_afull_%0d", i), almost_full, ((16 - i) >= 12) ? 1 : 0);
      end
      m_tready = 1'b0;
      check("drain_empty", m_tvalid, 0);
      clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
      check("clr_ovf", overflow, 0);
      check("clr_cnt", ovf_count, 0);

      // Clear coinciding with a new drop
      fill(8'h21);
      push(8'hE1); push(8'hE2);
      check("pre_clr_cnt", ovf_count, 2);
      clr_ovf = 1'b1; push(8'hE3); clr_ovf = 1'b0;
      check("clr_drop_ovf", overflow, 1);
      check("clr_drop_cnt", ovf_count, 1);
      clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
      check("clr2_cnt", ovf_count, 0);

      // Full with simultaneous pop
      m_tready = 1'b1; push(8'hAA); m_tready = 1'b0;
      check("fullpop_level", level, 16);
      check("fullpop_ovf", overflow, 0);
      check("fullpop_cnt", ovf_count, 0);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("fp_drain_%0d", i), m_tdata, (i < 15) ? 8'h22 + 8'(i) : 8'hAA);
         m_tready = 1'b1; tick();
      end
      m_tready = 1'b0;
      check("fp_empty", m_tvalid, 0);

      // Pointer wrap with random ready
      next_val = 8'h00; sent = 0;
      for (int cyc = 0; cyc < 2000 && (sent < 300 || q.size() != 0); cyc++) begin
         pcm_data_valid = (sent < 300) && (cyc % 2 == 0);
         pcm_data       = next_val;
         m_tready       = ($urandom_range(0, 3) != 0);
         check("wrap_tvalid", m_tvalid, (q.size() != 0) ? 1 : 0);
         check("wrap_level", level, q.size());
         if (q.size() != 0) check("wrap_tdata", m_tdata, q[0]);
         mpop  = (q.size() != 0) && m_tready;
         mpush = pcm_data_valid && ((q.size() < 16) || mpop);
         tick();
         if (mpop) void'(q.pop_front());
         if (mpush) begin
            q.push_back(next_val);
            next_val = next_val + 8'h01;
            sent++;
         end
      end
      pcm_data_valid = 1'b0; m_tready = 1'b0;
      check("wrap_sent", sent, 300);
      check("wrap_ovf", overflow, 0);
      check("wrap_empty", level, 0);

      // Asynchronous reset mid-stream
      for (int i = 0; i < 7; i++) push(8'h70 + 8'(i));
      check("mid_level", level, 7);
      rst = 1'b1; #1;
      check("mid_rst_tvalid", m_tvalid, 0);
      check("mid_rst_level", level, 0);
      check("mid_rst_cnt", ovf_count, 0);
      #2 rst = 1'b0;
      tick();
      push(8'h33);
      check("post_rst_tvalid", m_tvalid, 1);
      check("post_rst_data", m_tdata, 8'h33);
      check("post_rst_level", level, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
